// File: rtl/butterfly_port_scheduler.sv
// rtl/butterfly_port_scheduler.sv - 4-input round-robin output port scheduler with credit flow control (optional watchdog: ARB_WATCHDOG_EN)
module butterfly_port_scheduler #(
   parameter int CRED_MAX = 4,
   parameter int HOLD_MAX = 16
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [3:0] req,
   input  logic [3:0] tail,
   input  logic       credit_in,
   output logic [3:0] gnt,
   output logic [1:0] sel,
   output logic       out_valid,
   output logic       credit_err,
   output logic       timeout
);

   localparam logic [0:0] IDLE = 1'b0;
   localparam logic [0:0] BUSY = 1'b1;
   localparam logic [3:0] CRED_FULL = 4'(CRED_MAX);

   logic [0:0] state;
   logic [1:0] ptr;
   logic [3:0] credits;
   logic       armed;
   logic [1:0] pick;
   logic       force_rel;

   // Round-robin search: first requester at or after ptr+1, wrapping; lowest offset wins
   always_comb begin
      pick = ptr + 2'd1;
      for (int k = 4; k >= 1; k--) begin
         if (req[ptr + 2'(k)]) pick = ptr + 2'(k);
      end
   end

   assign out_valid = (state == BUSY) && req[sel] && (credits != 4'd0);

`ifdef ARB_WATCHDOG_EN
   localparam int WD_W = $clog2(HOLD_MAX + 1);
   logic [WD_W-1:0] wd_cnt;

   assign force_rel = (state == BUSY) && !out_valid && (wd_cnt == WD_W'(HOLD_MAX - 1));

   // Stall counter: BUSY cycles without a transfer; restarts on transfer, release or idle
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wd_cnt  <= '0;
         timeout <= 1'b0;
      end else begin
         timeout <= force_rel;
         if (state != BUSY || out_valid || force_rel) wd_cnt <= '0;
         else                                          wd_cnt <= wd_cnt + WD_W'(1);
      end
   end
`else
   logic hold_unused;
   assign hold_unused = (HOLD_MAX > 0);
   assign force_rel   = 1'b0;
   assign timeout     = 1'b0;
`endif

   // Arbitration FSM: grant in IDLE, hold owner in BUSY until tail transfer or watchdog
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state <= IDLE;
         gnt   <= 4'b0000;
         sel   <= 2'd0;
         ptr   <= 2'd3;
         armed <= 1'b0;
      end else begin
         // armed delays the first grant to the second edge after reset release
         armed <= 1'b1;
         if (state == IDLE) begin
            if (armed && (req != 4'b0000)) begin
               state <= BUSY;
               sel   <= pick;
               gnt   <= 4'b0001 << pick;
            end
         end else if ((out_valid && tail[sel]) || force_rel) begin
            state <= IDLE;
            gnt   <= 4'b0000;
            ptr   <= sel;
         end
      end
   end

   // Credit counter: -1 per transfer, +1 per returned credit, overflow is sticky error
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         credits    <= CRED_FULL;
         credit_err <= 1'b0;
      end else begin
         if (out_valid && !credit_in) begin
            credits <= credits - 4'd1;
         end else if (!out_valid && credit_in) begin
            if (credits == CRED_FULL) credit_err <= 1'b1;
            else                      credits    <= credits + 4'd1;
         end
      end
   end

endmodule

// File: tb/tb_butterfly_port_scheduler.sv
// tb/tb_butterfly_port_scheduler.sv - self-checking bench for butterfly_port_scheduler
module tb_butterfly_port_scheduler;

   localparam int CRED = 4;
   localparam int HOLD = 16;

   logic       clk = 1'b0;
   logic       rst;
   logic [3:0] req, tail;
   logic       credit_in;
   logic [3:0] gnt;
   logic [1:0] sel;
   logic       out_valid, credit_err, timeout;

   logic [3:0] req2, tail2;
   logic       ci2;
   logic [3:0] gnt2;
   logic [1:0] sel2;
   logic       ov2, err2, to2;

   int n_assert = 0;
   int n_fail   = 0;

   // reference model of the CRED=4 instance
   bit m_busy, m_armed, m_err, m_to;
   int m_owner, m_sel, m_ptr, m_cred, m_stall;

   // directed expectations for the early phase
   bit         e_en = 1'b0;
   logic [3:0] e_gnt1, e_gnt2;
   logic       e_ov2;

   always #5 clk = ~clk;

   butterfly_port_scheduler #(.CRED_MAX(CRED), .HOLD_MAX(HOLD)) dut (
      .clk(clk), .rst(rst), .req(req), .tail(tail), .credit_in(credit_in),
      .gnt(gnt), .sel(sel), .out_valid(out_valid), .credit_err(credit_err), .timeout(timeout)
   );

   butterfly_port_scheduler #(.CRED_MAX(2), .HOLD_MAX(HOLD)) dut2 (
      .clk(clk), .rst(rst), .req(req2), .tail(tail2), .credit_in(ci2),
      .gnt(gnt2), .sel(sel2), .out_valid(ov2), .credit_err(err2), .timeout(to2)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_busy = 0; m_armed = 0; m_err = 0; m_to = 0;
      m_owner = 0; m_sel = 0; m_ptr = 3; m_cred = CRED; m_stall = 0;
   endtask

   // Sample at the falling edge, compare to the model, advance the model, then pass the rising edge
   task automatic cycle();
      bit ov;
      bit wd_rel;
      @(negedge clk);
      ov = m_busy && req[m_owner] && (m_cred > 0);
      check("gnt", gnt, m_busy ? (32'd1 << m_owner) : 32'd0);
      check("sel", sel, m_sel);
      check("out_valid", out_valid, ov);
      check("credit_err", credit_err, m_err);
      check("timeout", timeout, m_to);
      check("credits", dut.credits, m_cred);
      if (e_en) begin
         check("rr_gnt", gnt, e_gnt1);
         check("cred2_gnt", gnt2, e_gnt2);
         check("cred2_ov", ov2, e_ov2);
      end
      if (ov && !credit_in)      m_cred--;
      else if (!ov && credit_in) begin
         if (m_cred == CRED) m_err = 1;
         else                m_cred++;
      end
      m_to = 0;
      wd_rel = 0;
`ifdef ARB_WATCHDOG_EN
      if (m_busy && !ov) begin
         if (m_stall == HOLD - 1) begin
            m_to = 1; wd_rel = 1; m_stall = 0;
         end else begin
            m_stall++;
         end
      end else begin
         m_stall = 0;
      end
`endif
      if (!m_busy) begin
         if (m_armed && req != 4'b0) begin
            for (int k = 1; k <= 4; k++) begin
               if (req[(m_ptr + k) % 4]) begin
                  m_busy = 1; m_owner = (m_ptr + k) % 4; m_sel = m_owner;
                  break;
               end
            end
         end
      end else if ((ov && tail[m_owner]) || wd_rel) begin
         m_busy = 0; m_ptr = m_owner;
      end
      m_armed = 1;
      @(posedge clk);
      #1;
   endtask

   int p_g1 [10] = '{0, 0, 1, 0, 2, 0, 4, 0, 8, 0};
   int p_g2 [10] = '{0, 0, 1, 1, 1, 1, 1, 1, 1, 1};
   int p_v2 [10] = '{0, 0, 1, 1, 0, 0, 0, 1, 0, 0};

   initial begin
      rst = 1'b0; req = 4'b0; tail = 4'b0; credit_in = 1'b0;
      req2 = 4'b0; tail2 = 4'b0; ci2 = 1'b0;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      check("reset_gnt", gnt, 4'b0);
      check("reset_credits", dut.credits, CRED);
      rst = 1'b1;

      // Round-robin with bubbles on dut; credit exhaustion and refill on dut2
      req = 4'b1111; tail = 4'b1111;
      req2 = 4'b0001;
      for (int i = 0; i < 10; i++) begin
         e_en = 1'b1;
         e_gnt1 = 4'(p_g1[i]); e_gnt2 = 4'(p_g2[i]); e_ov2 = 1'(p_v2[i]);
         ci2 = (i == 6);
         cycle();
      end
      e_en = 1'b0; ci2 = 1'b0; req2 = 4'b0;

      // Refill to full, then one overflow pulse
      req = 4'b0; tail = 4'b0;
      cycle();
      credit_in = 1'b1;
      repeat (5) cycle();
      credit_in = 1'b0;
      cycle();
      check("overflow_err", credit_err, 1'b1);
      check("overflow_credits", dut.credits, 4'd4);

      // Input 2 sends three flits while input 0 keeps requesting
      req = 4'b0100;
      cycle();
      req = 4'b0101;
      cycle();
      credit_in = 1'b1;
      cycle();
      credit_in = 1'b0; tail = 4'b0100;
      cycle();
      tail = 4'b0000;
      cycle();
      cycle();

      // Owner drops req without tail: grant holds (watchdog releases when enabled)
      req = 4'b0000;
      repeat (20) cycle();
      req = 4'b0001; tail = 4'b0001;
      repeat (3) cycle();

      // Refill, then reset in the middle of a packet between edges
      req = 4'b0; tail = 4'b0; credit_in = 1'b1;
      repeat (4) cycle();
      credit_in = 1'b0; req = 4'b0010;
      repeat (3) cycle();
      #2;
      rst = 1'b0;
      #1;
      check("async_gnt", gnt, 4'b0);
      check("async_credits", dut.credits, CRED);
      check("async_out_valid", out_valid, 1'b0);
      model_reset();
      @(posedge clk);
      #1;
      rst = 1'b1;
      req = 4'b0; tail = 4'b0;

      // Randomized traffic against the model
      for (int i = 0; i < 400; i++) begin
         req       = 4'($urandom);
         tail      = ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'b0;
         credit_in = ($urandom_range(0, 2) == 0);
         cycle();
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
